// File: rtl/lcb_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package  : lcb_fifo_pkg
// Brief    : Shared constants for the LCB sync FIFO and its read-side consumers.
// Revision : 1.0 - initial release
// ============================================================================
package lcb_fifo_pkg;

  // Read-side consumers rely on almost_empty meaning "one word or fewer".
  localparam int FIFO_ALMOST_EMPTY_THRESHOLD_RD = 1;
  localparam int FIFO_DATA_WIDTH_DEFAULT        = 16;
  localparam int FIFO_ADDR_WIDTH_DEFAULT        = 4;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_head_guard.sv
`default_nettype none
// ============================================================================
// Module   : fifo_head_guard
// Brief    : Flags when the FIFO head word on a registered BRAM read port is trustworthy.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_head_guard
  import lcb_fifo_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic fifo_empty,
  input  logic fifo_alm_empty,
  input  logic fifo_rd_en,
  output logic head_ok
);

  logic stale_q;
  logic stale_d;

  if (FIFO_ALMOST_EMPTY_THRESHOLD_RD != 1) begin : g_bad_threshold
    $error("fifo_head_guard requires an almost_empty threshold of 1");
  end

  // The read address was sampled while its word was being written, so the
  // BRAM returned the previous content of that location.
  always_comb begin
    stale_d = fifo_empty | (fifo_rd_en & fifo_alm_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stale_q <= 1'b1;
    end else begin
      stale_q <= stale_d;
    end
  end

  assign head_ok = ~fifo_empty & ~stale_q;

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Brief    : Drains the shared sync FIFO into a registered valid/ready stream.
// Options  : FIFO_STREAM_READER_LAST_EN enables the m_last burst marker.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
  import lcb_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEFAULT,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_alm_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  word_count
);

  logic                  head_ok;
  logic                  pop;
  logic                  m_valid_q;
  logic                  m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [DATA_WIDTH-1:0] m_data_d;
  logic [CNT_WIDTH-1:0]  word_count_q;
  logic [CNT_WIDTH-1:0]  word_count_d;

  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("fifo_stream_reader BURST_LEN must be at least 1");
  end

  fifo_head_guard u_head_guard (
    .clk            (clk),
    .reset          (reset),
    .fifo_empty     (fifo_empty),
    .fifo_alm_empty (fifo_alm_empty),
    .fifo_rd_en     (pop),
    .head_ok        (head_ok)
  );

  // Pop only into an empty or draining output register.
  assign pop        = head_ok & enable & (~m_valid_q | m_ready) & ~reset;
  assign fifo_rd_en = pop;

  always_comb begin
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    word_count_d = word_count_q;
    if (pop) begin
      m_valid_d = 1'b1;
      m_data_d  = fifo_rd_data;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
    if (m_valid_q & m_ready) begin
      word_count_d = word_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      word_count_q <= '0;
    end else begin
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      word_count_q <= word_count_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign word_count = word_count_q;

`ifdef FIFO_STREAM_READER_LAST_EN
  localparam int BURST_CNT_W = cnt_width(BURST_LEN);
  localparam logic [BURST_CNT_W-1:0] BURST_CNT_MAX = BURST_CNT_W'(BURST_LEN - 1);

  logic [BURST_CNT_W-1:0] burst_cnt_q;
  logic [BURST_CNT_W-1:0] burst_cnt_d;
  logic                   m_last_q;
  logic                   m_last_d;

  // The marker travels with the popped word, so it only updates on a pop.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    m_last_d    = m_last_q;
    if (pop) begin
      m_last_d    = (burst_cnt_q == BURST_CNT_MAX);
      burst_cnt_d = (burst_cnt_q == BURST_CNT_MAX) ? '0 : burst_cnt_q + BURST_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt_q <= '0;
      m_last_q    <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      m_last_q    <= m_last_d;
    end
  end

  assign m_last = m_last_q;
`else
  assign m_last = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Brief    : Scoreboard bench for fifo_stream_reader behind a 16-deep sync FIFO
//            with a registered read-first BRAM port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;
  import lcb_fifo_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = FIFO_ADDR_WIDTH_DEFAULT;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = 32;
`ifdef FIFO_STREAM_READER_LAST_EN
  localparam int BL      = 4;
  localparam bit LAST_EN = 1'b1;
`else
  localparam int BL      = 16;
  localparam bit LAST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          m_ready = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_empty, fifo_alm_empty, fifo_full, fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last;
  logic [CW-1:0] word_count;

  always #5 clk = ~clk;

  // Sync FIFO: registered read-first BRAM, ALMOST_EMPTY_THRESHOLD=1.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          do_wr, do_rd;

  assign fifo_empty     = (count == 0);
  assign fifo_alm_empty = (count <= (AW+1)'(FIFO_ALMOST_EMPTY_THRESHOLD_RD));
  assign fifo_full      = (count == (AW+1)'(DEPTH));
  assign do_wr          = wr_en & ~fifo_full;
  assign do_rd          = fifo_rd_en & ~fifo_empty;

  always @(posedge clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      fifo_rd_data <= 16'hDEAD;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'hDEAD;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      fifo_rd_data <= mem[do_rd ? rd_ptr + AW'(1) : rd_ptr];
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd) count <= count + (AW+1)'(1);
      else if (!do_wr && do_rd) count <= count - (AW+1)'(1);
    end
  end

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .fifo_rd_data   (fifo_rd_data),
    .fifo_empty     (fifo_empty),
    .fifo_alm_empty (fifo_alm_empty),
    .fifo_rd_en     (fifo_rd_en),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .word_count     (word_count)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    hs_cyc[$];
  int    total = 0;
  int    bad = 0;
  int    push_idx = 0;
  int    cycle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Monitor: scoreboard pops, handshake stability and pop legality.
  logic    prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic    prev_last = 1'b0;
  beat_t   mon_e;

  always @(negedge clk) begin
    cycle++;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      check("pop_on_empty", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
      if (prev_hold) begin
        check("hold_valid", {31'd0, m_valid}, 32'd1);
        check("hold_data", {16'd0, m_data}, {16'd0, prev_data});
        check("hold_last", {31'd0, m_last}, {31'd0, prev_last});
      end
      if (m_valid && !m_ready) check("pop_while_stalled", {31'd0, fifo_rd_en}, 32'd0);
      if (m_valid && m_ready) begin
        hs_cyc.push_back(cycle);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h expected none", m_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("m_data", {16'd0, m_data}, {16'd0, mon_e.data});
          check("m_last", {31'd0, m_last}, {31'd0, mon_e.last});
        end
      end
      prev_hold = m_valid & ~m_ready;
      prev_data = m_data;
      prev_last = m_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    int n;
    n = 0;
    while (fifo_full && n < 100) begin
      tick();
      n++;
    end
    if (fifo_full) begin
      fail("push_full");
    end else begin
      wr_en   = 1'b1;
      wr_data = d;
      exp_q.push_back('{data: d, last: (LAST_EN && ((push_idx % BL) == BL - 1))});
      push_idx++;
      tick();
      wr_en = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 300) begin
      tick();
      n++;
    end
    check("drain_left", exp_q.size(), 32'd0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    if (!m_valid) fail(name);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    m_ready = 1'b1;
    wr_en   = 1'b0;
    #1;
    check("rst_no_pop", {31'd0, fifo_rd_en}, 32'd0);
    exp_q.delete();
    push_idx = 0;
    tick();
    tick();
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_data", {16'd0, m_data}, 32'd0);
    check("rst_last", {31'd0, m_last}, 32'd0);
    check("rst_count", word_count, 32'd0);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    repeat (3) tick();
    check("init_valid", {31'd0, m_valid}, 32'd0);
    check("init_data", {16'd0, m_data}, 32'd0);
    check("init_last", {31'd0, m_last}, 32'd0);
    check("init_count", word_count, 32'd0);
    check("init_no_pop", {31'd0, fifo_rd_en}, 32'd0);
    reset = 1'b0;
    tick();

    // Single word into an empty FIFO: valid appears on the third edge.
    push(16'hA5A5);
    check("lat_valid_e0", {31'd0, m_valid}, 32'd0);
    tick();
    check("lat_valid_e1", {31'd0, m_valid}, 32'd0);
    check("lat_pop_e1", {31'd0, fifo_rd_en}, 32'd1);
    tick();
    check("lat_valid_e2", {31'd0, m_valid}, 32'd1);
    check("lat_data_e2", {16'd0, m_data}, 32'h0000A5A5);
    drain();
    check("lat_count", word_count, 32'd1);

    // Back-to-back burst at one word per cycle.
    base = hs_cyc.size();
    for (int i = 0; i < 16; i++) push(DW'(i));
    drain();
    if (hs_cyc.size() >= base + 16)
      check("burst_span", hs_cyc[base + 15] - hs_cyc[base], 32'd15);
    else
      fail("burst_words");
    check("burst_count", word_count, 32'd17);

    // Count hovers at one: each pop of the last word coincides with a write.
    push(16'h1000);
    for (int i = 1; i <= 6; i++) begin
      n = 0;
      while (!fifo_rd_en && n < 20) begin
        tick();
        n++;
      end
      if (!fifo_rd_en) fail("hover_wait_pop");
      push(16'h1000 + DW'(i));
      check("hover_bubble", {31'd0, fifo_rd_en}, 32'd0);
      check("hover_level", {27'd0, count}, 32'd1);
    end
    drain();
    check("hover_count", word_count, push_idx);

    // Consumer stall until the FIFO is full.
    for (int i = 0; i < 3; i++) push(16'h2000 + DW'(i));
    m_ready = 1'b0;
    n = 3;
    while (!fifo_full && n < 24) begin
      push(16'h2000 + DW'(n));
      n++;
    end
    check("stall_full", {31'd0, fifo_full}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_no_pop", {31'd0, fifo_rd_en}, 32'd0);
      check("stall_valid", {31'd0, m_valid}, 32'd1);
    end
    m_ready = 1'b1;
    drain();
    check("stall_count", word_count, push_idx);

    // Disable with four words queued.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h3000 + DW'(i));
    wait_valid("en_wait_valid");
    enable  = 1'b0;
    m_ready = 1'b1;
    repeat (4) tick();
    check("en_valid_off", {31'd0, m_valid}, 32'd0);
    check("en_no_pop", {31'd0, fifo_rd_en}, 32'd0);
    check("en_fifo_left", {27'd0, count}, 32'd3);
    check("en_count_mid", word_count, push_idx - 3);
    enable = 1'b1;
    drain();
    check("en_count", word_count, push_idx);

    // Burst markers over ten words from a fresh reset.
    do_reset();
    for (int i = 0; i < 10; i++) push(16'h4000 + DW'(i));
    drain();
    check("last_count10", word_count, 32'd10);

    // Six words, then a reset with a word held, then a fresh burst.
    do_reset();
    for (int i = 0; i < 6; i++) push(16'h4100 + DW'(i));
    drain();
    check("last_count6", word_count, 32'd6);
    m_ready = 1'b0;
    push(16'h4200);
    push(16'h4201);
    wait_valid("mid_wait_valid");
    do_reset();
    for (int i = 0; i < 4; i++) push(16'h4300 + DW'(i));
    drain();
    check("restart_count", word_count, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
